// File: rtl/mips_pkg.sv
// Shared MIPS core constants: register-file geometry and writeback requester indices.
package mips_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // Writeback producers, in arbitration index order
    localparam int WB_LOAD   = 0;
    localparam int WB_MULDIV = 1;
    localparam int WB_ALU    = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Generic NREQ-way round-robin arbiter: one-hot grant, search starts at the
// pointer, pointer moves just past the winner whenever a grant is issued.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] gidx;
    logic          found;
    int            idx;

    // First requester at or after the pointer wins; the grant implies the
    // requester is valid, so a grant is always a transfer.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
        if (found) begin
            gnt_o[gidx] = 1'b1;
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // Pointer register; holds on idle cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: round-robin shares the single write
// port among writeback producers, registers the write, and keeps a per-register
// pending scoreboard for decode stalls.
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_addr,
    input  logic [AW-1:0]      chk_addr1,
    input  logic [AW-1:0]      chk_addr2,
    output logic               chk_busy,
    output logic [2**AW-1:0]   pending,
    output logic               err_unexpected
);

    localparam int NR = 2**AW;

    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] gnt;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    logic            rf_we_q,    rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic [NR-1:0]   pending_q,  pending_d;
    logic            err_q,      err_d;

    // No grants while reset is held.
    assign arb_req = req_valid & {NREQ{~rst}};

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk_i(clk),
        .rst_i(rst),
        .req_i(arb_req),
        .gnt_o(gnt)
    );

    assign req_ready = gnt;

    // Mux the granted requester's destination and data.
    always_comb begin
        xfer     = |gnt;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Next state: writeback register, scoreboard (set beats clear), sticky error.
    always_comb begin
        rf_we_d    = xfer && (sel_addr != '0);
        rf_waddr_d = xfer ? sel_addr : rf_waddr_q;
        rf_wdata_d = xfer ? sel_data : rf_wdata_q;

        pending_d = pending_q;
        if (rf_we_q) begin
            pending_d[rf_waddr_q] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            pending_d[issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;

        err_d = err_q | (xfer && (sel_addr != '0) && !pending_q[sel_addr]);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
        end
    end

    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign pending        = pending_q;
    assign err_unexpected = err_q;
    assign chk_busy       = pending_q[chk_addr1] | pending_q[chk_addr2];

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the MIPS 32×32-bit register file. Shares the file's single write port among NREQ writeback producers (load unit, mul/div unit, ALU) using round-robin arbitration with valid/ready handshakes, and drives the file's write-enable, write-address and write-data inputs from registers. Keeps a per-register pending scoreboard so decode can stall on operands whose producer has not yet written back.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters (index 0 load, 1 mul/div, 2 ALU)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- req_addr  in  NREQ*AW  destination of requester i, slice [i*AW +: AW]
- req_data  in  NREQ*DW  data of requester i, slice [i*DW +: DW]
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  DW  register-file write data (registered)
- issue_valid  in  1  an instruction writing issue_addr was issued this cycle
- issue_addr  in  AW  destination of the issued instruction
- chk_addr1, chk_addr2  in  AW each  decode source operands
- chk_busy  out  1  combinational: either source is pending
- pending  out  2**AW  scoreboard vector
- err_unexpected  out  1  sticky: write granted to a non-pending, non-zero register

## Operation
- Arbitration: rr_ptr (0..NREQ-1). Grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NREQ. At most one req_ready bit high. No valid → req_ready all 0.
- req_ready is combinational from req_valid and rr_ptr; requesters must not make valid depend on ready.
- On transfer of requester g: rr_ptr ← (g+1) mod NREQ; rr_ptr unchanged on idle cycles.
- Writeback register: each cycle rf_we ← transfer & (addr ≠ 0); on transfer rf_waddr/rf_wdata ← granted addr/data; otherwise hold. Writes to $0 are granted (consumed) but never raise rf_we.
- Scoreboard: issue_valid & issue_addr ≠ 0 sets pending[issue_addr]; rf_we clears pending[rf_waddr] at the same edge the file writes. Same address set and cleared together → set wins (new producer in flight). pending[0] is always 0.
- chk_busy = pending[chk_addr1] | pending[chk_addr2]; address 0 never busy.
- err_unexpected set on a transfer with addr ≠ 0 and pending[addr] = 0; cleared only by rst.

## Timing
- Reset (rst high at an edge): rr_ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0, pending=all 0, err_unexpected=0. While rst is high req_ready=all 0 (no transfers); issue_valid is ignored.
- Latency: transfer in cycle T → rf_we high in T+1 → file written at end of T+1; pending bit drops at that same edge, so chk_busy stays high through T+1 and falls in T+2.
- Throughput: one write per cycle; back-to-back transfers from different requesters give rf_we high on consecutive cycles.
- Fairness: with all NREQ requesters continuously valid, each is granted once every NREQ cycles.
- Requester holding valid without ready keeps addr/data stable until transfer.

## Structure
- Shared package mips_pkg: REG_AW=5, DATA_W=32, NUM_REGS=32, requester indices WB_LOAD=0, WB_MULDIV=1, WB_ALU=2.
- One sub-module: rr_arbiter (generic NREQ round-robin, one-hot grant, pointer advance on accept); scoreboard and writeback registers live in the top.

## Test plan
- Reset: drive rst 2 cycles with all req_valid=1 → req_ready=000, rf_we=0, pending=0, err_unexpected=0.
- Issue $5 (issue_addr=5), then ALU req addr=5 data=0xDEADBEEF → ready[2] same cycle, rf_we=1/rf_waddr=5/rf_wdata=0xDEADBEEF next cycle; chk_addr1=5 busy until the cycle after rf_we, then 0.
- All three valid continuously for 6 cycles (issued dests 1,2,3) → grants 0,1,2,0,1,2 with rr_ptr starting at 0.
- Req to $0 with data 0x1234 → granted, rf_we stays 0, err_unexpected stays 0.
- Same-edge issue of $7 and rf_we writing $7 → pending[7]=1 afterwards.
- Transfer to $9 with pending[9]=0 → err_unexpected=1 and stays 1 until rst.
